// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg
// Shared constants for the ALU execute stage: operation codes, shift
// select codes, FSM state encoding and parameter defaults.
// Optional feature macro: ALU_EXEC_SRA_EN (used by alu_exec_unit).
package alu_exec_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int JAL_OFFSET_DEF = 8;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_NOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_LUI = 3'b101;
   localparam logic [2:0] OP_JAL = 3'b110;
   localparam logic [2:0] OP_BAD = 3'b111;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_SLL  = 2'b01;
   localparam logic [1:0] SH_SRL  = 2'b10;
   localparam logic [1:0] SH_SRA  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_exec_shifter.sv
// alu_exec_shifter
// Iterative one-bit-per-cycle shifter: a working register plus a 5-bit
// down-counter. Direction and fill mode are captured at load so the
// caller's inputs may change freely while the shift runs.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture din/shamt/dir/arith
//   dir         : 0 = left, 1 = right
//   arith       : right shifts replicate the sign bit
//   shamt       : number of single-bit steps
//   din         : value to be shifted
//   value       : working register shifted by one more step, i.e. the
//                 value it will hold after the current edge
//   last        : the current edge performs the final step
module alu_exec_shifter
   import alu_exec_pkg::*;
#(
   parameter int W = DATA_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dir,
   input  logic         arith,
   input  logic [4:0]   shamt,
   input  logic [W-1:0] din,
   output logic [W-1:0] value,
   output logic         last
);

   logic [W-1:0] work;
   logic [4:0]   cnt;
   logic         dir_q;
   logic         arith_q;
   logic         fill;

   always_ff @(posedge clk) begin
      if (reset) begin
         work    <= '0;
         cnt     <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else if (load) begin
         work    <= din;
         cnt     <= shamt;
         dir_q   <= dir;
         arith_q <= arith;
      end else if (cnt != 5'd0) begin
         work <= value;
         cnt  <= cnt - 5'd1;
      end
   end

   assign fill  = arith_q & work[W-1];
   assign value = dir_q ? {fill, work[W-1:1]} : {work[W-2:0], 1'b0};
   assign last  = (cnt == 5'd1);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute stage after the ALU control decoder. Logic, add/sub, LUI and
// JAL complete in one cycle; SLL/SRL (and SRA when ALU_EXEC_SRA_EN is
// defined) run one bit per cycle through alu_exec_shifter.
// Optional feature macro: ALU_EXEC_SRA_EN -- when undefined, shift_sel=11
// is reported as illegal and no sign-fill path exists.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : request, accepted in IDLE or DONE
//   alu_operation     : 3-bit operation code
//   shift_sel         : 00 none, 01 SLL, 10 SRL, 11 SRA; non-zero wins
//   shamt             : shift amount
//   a, b              : operands (b is the shifted operand)
//   busy              : shift in progress
//   done              : one-cycle pulse, result valid from this cycle
//   result, zero      : registered result and its zero flag
//   overflow, illegal : signed ADD/SUB overflow; unsupported code
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | iterative shift running, busy=1
// ST_DONE  | result just loaded, done=1, may accept start
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int JAL_OFFSET = JAL_OFFSET_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            alu_operation,
   input  logic [1:0]            shift_sel,
   input  logic [4:0]            shamt,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero,
   output logic                  overflow,
   output logic                  illegal
);

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] alu_r;
   logic                  alu_ovf;
   logic                  alu_ill;
   logic                  shift_legal;
   logic                  accept;
   logic                  shift_go;
   logic                  sh_arith;
   logic [DATA_WIDTH-1:0] sh_value;
   logic                  sh_last;

   assign sum  = a + b;
   assign diff = a - b;

   // For a legal shift the combinational result is just b; it is only
   // used directly when shamt is 0.
   always_comb begin
      alu_r       = '0;
      alu_ovf     = 1'b0;
      alu_ill     = 1'b0;
      shift_legal = 1'b0;
      if (shift_sel == SH_NONE) begin
         case (alu_operation)
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_NOR: alu_r = ~(a | b);
            OP_ADD: begin
               alu_r   = sum;
               alu_ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &
                         (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
               alu_r   = diff;
               alu_ovf = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &
                         (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_LUI: alu_r = {b[15:0], {(DATA_WIDTH-16){1'b0}}};
            OP_JAL: alu_r = a + DATA_WIDTH'(JAL_OFFSET);
            default: alu_ill = 1'b1;
         endcase
      end else if ((shift_sel == SH_SLL) || (shift_sel == SH_SRL)) begin
         alu_r       = b;
         shift_legal = 1'b1;
      end else begin
`ifdef ALU_EXEC_SRA_EN
         alu_r       = b;
         shift_legal = 1'b1;
`else
         alu_ill     = 1'b1;
`endif
      end
   end

`ifdef ALU_EXEC_SRA_EN
   assign sh_arith = (shift_sel == SH_SRA);
`else
   assign sh_arith = 1'b0;
`endif

   assign accept   = start & ((state == ST_IDLE) | (state == ST_DONE));
   assign shift_go = accept & shift_legal & (shamt != 5'd0);

   alu_exec_shifter #(
      .W (DATA_WIDTH)
   ) u_shifter (
      .clk   (clk),
      .reset (reset),
      .load  (shift_go),
      .dir   (shift_sel[1]),
      .arith (sh_arith),
      .shamt (shamt),
      .din   (b),
      .value (sh_value),
      .last  (sh_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_nxt = shift_go ? ST_SHIFT : ST_DONE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (sh_last) begin
               state_nxt = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         illegal  <= 1'b0;
      end else if (accept && !shift_go) begin
         result   <= alu_r;
         zero     <= (alu_r == '0);
         overflow <= alu_ovf;
         illegal  <= alu_ill;
      end else if ((state == ST_SHIFT) && sh_last) begin
         result   <= sh_value;
         zero     <= (sh_value == '0);
         overflow <= 1'b0;
         illegal  <= 1'b0;
      end
   end

   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);

endmodule
